// File: rtl/tea_cipher_core.sv
// TEA block cipher core: one full round per clock, IDLE/RUN/DONE handshake.
`timescale 1ns/1ps
module tea_cipher_core #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [31:0]  in_v0,
  input  logic [31:0]  in_v1,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_v0,
  output logic [31:0]  out_v1,
  output logic         busy
);

  localparam int unsigned W       = 32;
  localparam int unsigned CW      = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST  = CW'(ROUNDS - 1);
  localparam logic [W-1:0] SUM_DEC = W'(64'(DELTA) * 64'(ROUNDS));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [127:0]    key_q, key_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    out_v0_q, out_v0_d, out_v1_q, out_v1_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            idle_q, idle_d;

  logic [W-1:0]    k0, k1, k2, k3;
  logic [W-1:0]    enc_sum, enc_v0, enc_v1, dec_sum, dec_v0, dec_v1;
  logic [W-1:0]    rnd_v0, rnd_v1, rnd_sum;
  logic            accept;

  function automatic logic [W-1:0] mix(input logic [W-1:0] v, input logic [W-1:0] s,
                                       input logic [W-1:0] ka, input logic [W-1:0] kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  assign k0 = key_q[31:0];
  assign k1 = key_q[63:32];
  assign k2 = key_q[95:64];
  assign k3 = key_q[127:96];

  // idle_q stays low for the first cycle after reset so in_ready is held off.
  assign in_ready  = idle_q & ~clear;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_v0    = out_v0_q;
  assign out_v1    = out_v1_q;
  assign busy      = busy_q;

  // One full encrypt or decrypt round from the working registers.
  always_comb begin
    enc_sum = sum_q + DELTA;
    enc_v0  = v0_q + mix(v1_q, enc_sum, k0, k1);
    enc_v1  = v1_q + mix(enc_v0, enc_sum, k2, k3);
    dec_sum = sum_q - DELTA;
    dec_v1  = v1_q - mix(v0_q, sum_q, k2, k3);
    dec_v0  = v0_q - mix(dec_v1, sum_q, k0, k1);
    rnd_v0  = mode_q ? dec_v0  : enc_v0;
    rnd_v1  = mode_q ? dec_v1  : enc_v1;
    rnd_sum = mode_q ? dec_sum : enc_sum;
  end

  // Next-state and register-next logic; clear overrides everything on the state path.
  always_comb begin
    state_d     = state_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    sum_d       = sum_q;
    key_d       = key_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_v0_d    = out_v0_q;
    out_v1_d    = out_v1_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          v0_d    = in_v0;
          v1_d    = in_v1;
          key_d   = key;
          mode_d  = mode;
          cnt_d   = '0;
          sum_d   = mode ? SUM_DEC : '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        v0_d  = rnd_v0;
        v1_d  = rnd_v1;
        sum_d = rnd_sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          out_v0_d    = rnd_v0;
          out_v1_d    = rnd_v1;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
    busy_d = (state_d == S_RUN);
    idle_d = (state_d == S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      v0_q        <= '0;
      v1_q        <= '0;
      sum_q       <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      out_v0_q    <= '0;
      out_v1_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      sum_q       <= sum_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_v0_q    <= out_v0_d;
      out_v1_q    <= out_v1_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      idle_q      <= idle_d;
    end
  end

endmodule

// File: tb/tb_tea_cipher_core.sv
// Directed bench for tea_cipher_core: three instances (ROUNDS = 32, 1, 64).
`timescale 1ns/1ps
module tb_tea_cipher_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn, clear, mode;
  logic [31:0]  in_v0, in_v1;
  logic [127:0] key;
  logic         in_valid_a [3];
  logic         out_ready_a[3];
  logic         in_ready_a [3];
  logic         out_valid_a[3];
  logic         busy_a     [3];
  logic [31:0]  out_v0_a   [3];
  logic [31:0]  out_v1_a   [3];

  int n_checks = 0;
  int n_fail   = 0;

  tea_cipher_core #(.ROUNDS(32)) u_dut32 (
    .clk(clk), .resetn(resetn), .clear(clear), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .mode(mode), .in_v0(in_v0), .in_v1(in_v1), .key(key), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .out_v0(out_v0_a[0]), .out_v1(out_v1_a[0]), .busy(busy_a[0]));

  tea_cipher_core #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .clear(clear), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .mode(mode), .in_v0(in_v0), .in_v1(in_v1), .key(key), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .out_v0(out_v0_a[1]), .out_v1(out_v1_a[1]), .busy(busy_a[1]));

  tea_cipher_core #(.ROUNDS(64)) u_dut64 (
    .clk(clk), .resetn(resetn), .clear(clear), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .mode(mode), .in_v0(in_v0), .in_v1(in_v1), .key(key), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]), .out_v0(out_v0_a[2]), .out_v1(out_v1_a[2]), .busy(busy_a[2]));

  typedef struct {
    int           d;
    logic         mode;
    logic [31:0]  v0;
    logic [31:0]  v1;
    logic [127:0] key;
    logic [31:0]  e0;
    logic [31:0]  e1;
  } vec_t;

  localparam logic [127:0] K4321 = 128'h00000004_00000003_00000002_00000001;

  function automatic int rounds_of(input int d);
    return (d == 0) ? 32 : (d == 1) ? 1 : 64;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input int d, input logic m, input logic [31:0] a, input logic [31:0] b,
                       input logic [127:0] k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready_a[d]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("in_ready_timeout", 64'(ok), 64'd1);
    mode = m; in_v0 = a; in_v1 = b; key = k;
    in_valid_a[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
    chk("busy_after_accept", 64'(busy_a[d]), 64'd1);
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!out_valid_a[d] && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input int d);
    out_ready_a[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[d] = 1'b0;
    chk("out_valid_after_take", 64'(out_valid_a[d]), 64'd0);
    chk("in_ready_after_take", 64'(in_ready_a[d]), 64'd1);
  endtask

  task automatic run_block(input int d, input logic m, input logic [31:0] a, input logic [31:0] b,
                           input logic [127:0] k, output logic [31:0] r0, output logic [31:0] r1);
    int lat;
    start(d, m, a, b, k);
    wait_done(d, lat);
    chk("latency", 64'(lat), 64'(rounds_of(d)));
    r0 = out_v0_a[d];
    r1 = out_v1_a[d];
    drain(d);
  endtask

  task automatic no_valid_for(input int d, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (out_valid_a[d]) seen = 1'b1;
    end
    chk("spurious_out_valid", 64'(seen), 64'd0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [31:0] r0, r1, c0, c1, p0, p1, a, b;
    logic [127:0] k;
    int lat;

    resetn = 1'b0; clear = 1'b0; mode = 1'b0; in_v0 = '0; in_v1 = '0; key = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i] = 1'b0;
      out_ready_a[i] = 1'b0;
    end

    // Reset values and release
    #2;
    chk("rst_in_ready", 64'(in_ready_a[0]), 64'd0);
    chk("rst_busy", 64'(busy_a[0]), 64'd0);
    chk("rst_out_valid", 64'(out_valid_a[0]), 64'd0);
    chk("rst_out", {out_v0_a[0], out_v1_a[0]}, 64'd0);
    @(posedge clk); #1;
    chk("rst_in_ready_held", 64'(in_ready_a[0]), 64'd0);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 64'(in_ready_a[0]), 64'd1);
    chk("release_in_ready_64", 64'(in_ready_a[2]), 64'd1);

    // Directed vectors
    vecs[0] = '{0, 1'b0, 32'h0,        32'h0,        128'h0, 32'h41EA3A0A, 32'h94BAA940};
    vecs[1] = '{0, 1'b1, 32'h41EA3A0A, 32'h94BAA940, 128'h0, 32'h0,        32'h0};
    vecs[2] = '{1, 1'b0, 32'h0,        32'h0,        128'h0, 32'h9E3779B9, 32'hDBE8D32F};
    vecs[3] = '{1, 1'b1, 32'h9E3779B9, 32'hDBE8D32F, 128'h0, 32'h0,        32'h0};
    vecs[4] = '{1, 1'b0, 32'h0,        32'h0,        K4321,  32'h9E3779BA, 32'hDBE8D301};
    vecs[5] = '{1, 1'b1, 32'h9E3779BA, 32'hDBE8D301, K4321,  32'h0,        32'h0};
    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].d, vecs[i].mode, vecs[i].v0, vecs[i].v1, vecs[i].key, r0, r1);
      chk("vec_v0", 64'(r0), 64'(vecs[i].e0));
      chk("vec_v1", 64'(r1), 64'(vecs[i].e1));
      chk("vec_hold_after_idle", {out_v0_a[vecs[i].d], out_v1_a[vecs[i].d]}, {vecs[i].e0, vecs[i].e1});
    end

    // Hold DONE for 10 cycles with a stray in_valid pulse
    start(0, 1'b0, 32'h0, 32'h0, 128'h0);
    wait_done(0, lat);
    chk("hold_latency", 64'(lat), 64'd32);
    for (int i = 0; i < 10; i++) begin
      in_valid_a[0] = (i == 3);
      mode = 1'b1; in_v0 = 32'hDEADBEEF;
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(out_valid_a[0]), 64'd1);
      chk("hold_out", {out_v0_a[0], out_v1_a[0]}, 64'h41EA3A0A_94BAA940);
      chk("hold_in_ready", 64'(in_ready_a[0]), 64'd0);
      chk("hold_busy", 64'(busy_a[0]), 64'd0);
    end
    in_valid_a[0] = 1'b0;
    drain(0);

    // Clear in RUN cycle 5, then a fresh block round-trips
    a = 32'h12345678; b = 32'h9ABCDEF0; k = 128'h0123456789ABCDEF_FEDCBA9876543210;
    start(0, 1'b0, a, b, k);
    repeat (4) begin
      @(posedge clk); #1;
    end
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", 64'(in_ready_a[0]), 64'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    chk("clear_busy", 64'(busy_a[0]), 64'd0);
    chk("clear_out_valid", 64'(out_valid_a[0]), 64'd0);
    chk("clear_in_ready", 64'(in_ready_a[0]), 64'd1);
    chk("clear_keeps_result", {out_v0_a[0], out_v1_a[0]}, 64'h41EA3A0A_94BAA940);
    no_valid_for(0, 40);
    run_block(0, 1'b0, a, b, k, c0, c1);
    run_block(0, 1'b1, c0, c1, k, p0, p1);
    chk("clear_then_roundtrip", {p0, p1}, {a, b});

    // Clear beats the output handshake in DONE
    start(0, 1'b0, 32'h0, 32'h0, 128'h0);
    wait_done(0, lat);
    clear = 1'b1; out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; out_ready_a[0] = 1'b0;
    chk("clear_done_out_valid", 64'(out_valid_a[0]), 64'd0);
    chk("clear_done_result", {out_v0_a[0], out_v1_a[0]}, 64'h41EA3A0A_94BAA940);

    // Reset in RUN cycle 10
    start(0, 1'b0, a, b, k);
    repeat (9) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready_a[0]), 64'd0);
    chk("midrst_busy", 64'(busy_a[0]), 64'd0);
    chk("midrst_out_valid", 64'(out_valid_a[0]), 64'd0);
    chk("midrst_out", {out_v0_a[0], out_v1_a[0]}, 64'd0);
    @(posedge clk); #1;
    chk("midrst_in_ready_held", 64'(in_ready_a[0]), 64'd0);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_ready", 64'(in_ready_a[0]), 64'd1);
    no_valid_for(0, 40);

    // Random round-trips on all three round counts
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 2; j++) begin
        a = $urandom; b = $urandom;
        k = {$urandom, $urandom, $urandom, $urandom};
        run_block(d, 1'b0, a, b, k, c0, c1);
        run_block(d, 1'b1, c0, c1, k, p0, p1);
        chk("random_roundtrip", {p0, p1}, {a, b});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tea_cipher_core.md
TEA_CIPHER_CORE -- requirements
Module: tea_cipher_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock port clk, reset port resetn.
REQ-002 Parameter ROUNDS, default 32, SHALL set the rounds per block; legal range 1..64.
REQ-003 Parameter DELTA, default 32'h9E3779B9, SHALL set the key-schedule constant.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 clear  input  1  synchronous abort; returns the block to IDLE.
REQ-007 in_valid  input  1  a block and key are presented.
REQ-008 in_ready  output  1  the block accepts input this cycle.
REQ-009 mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-010 in_v0, in_v1  input  32 each  input block halves.
REQ-011 key  input  128  k0 = key[31:0], k1 = key[63:32], k2 = key[95:64], k3 = key[127:96].
REQ-012 out_valid  output  1  result held on out_v0/out_v1.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 out_v0, out_v1  output  32 each  result block halves.
REQ-015 busy  output  1  high in RUN.

Function
REQ-016 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE, with clear low.
REQ-018 Accept occurs on in_valid && in_ready; on that edge the block SHALL:
- latch v0, v1, key and mode;
- set the round counter to 0;
- set sum to 0 for encrypt, or to (DELTA*ROUNDS) mod 2^32 for decrypt;
- go to RUN.
REQ-019 Each RUN cycle SHALL perform exactly one full round (both halves); the counter SHALL increment by 1.
REQ-020 Encrypt round, using the updated sum and the updated v0:
- s = sum + DELTA;
- v0 += ((v1<<4)+k0) ^ (v1+s) ^ ((v1>>5)+k1);
- v1 += ((v0<<4)+k2) ^ (v0+s) ^ ((v0>>5)+k3);
- sum = s.
REQ-021 Decrypt round, using the updated v1:
- v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3);
- v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1);
- sum -= DELTA.
REQ-022 All arithmetic SHALL be modulo 2^32, with logical shifts.
REQ-023 The edge that completes round ROUNDS SHALL move the block to DONE and set out_valid = 1.
- out_valid is first high exactly ROUNDS cycles after the accept edge.
REQ-024 In DONE, out_v0/out_v1 and out_valid SHALL stay stable until out_valid && out_ready.
- On that edge: go to IDLE, out_valid = 0.
- The next accept is possible one cycle later; there is no same-cycle accept.
REQ-025 out_v0/out_v1 SHALL keep their last result after leaving DONE, until the next completion.
REQ-026 in_valid while busy SHALL be ignored: not accepted, no state change.
REQ-027 clear SHALL force IDLE and out_valid = 0 in any state, with priority over accept and over the out handshake.
- Result registers are left unchanged.
REQ-028 out_ready outside DONE SHALL have no effect.
REQ-029 The round counter width SHALL be $clog2(ROUNDS+1); there is no wrap-around within a block.

Reset
REQ-030 On resetn low, asynchronously, the block SHALL set:
- state = IDLE;
- out_valid = 0, busy = 0;
- out_v0 = out_v1 = 0;
- counter = 0, sum = 0;
- working v0/v1 and key = 0.
REQ-031 in_ready SHALL be 0 while resetn is low and 1 on the first clock after release, with clear low.
REQ-032 Reset mid-RUN or mid-DONE SHALL abandon the block; no out_valid SHALL appear for it.

Verification
REQ-033 ROUNDS=32, encrypt, key=0, v=(0,0) -> out_valid 32 cycles after accept, out=(32'h41EA3A0A, 32'h94BAA940).
REQ-034 Decrypt of (32'h41EA3A0A, 32'h94BAA940) with key=0 -> (0,0); initial decrypt sum = 32'hC6EF3720.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> out_v0/out_v1/out_valid stable; in_ready=0; a pulse on in_valid is not accepted.
REQ-036 Assert clear in RUN cycle 5 -> IDLE next edge, no out_valid; a new accept then yields the correct result.
REQ-037 resetn low in RUN cycle 10 -> all outputs 0 immediately; after release, in_ready=1 one cycle later.
REQ-038 ROUNDS=1 and ROUNDS=64 with random key/block -> decrypt(encrypt(x)) == x, latency equals ROUNDS.
